// File: rtl/lattice_scheduler_if.sv
// Host/lattice-facing bundle of the lattice job scheduler.
// Every valid/ready pair transfers on a cycle where both are high; a producer holds data stable until then.
interface lattice_scheduler_if #(
   parameter int ID_W = 8
);
   logic            work_valid;
   logic            work_ready;
   logic [255:0]    work_midstate;
   logic [95:0]     work_tail;
   logic [ID_W-1:0] work_id;

   logic            lat_valid;
   logic            lat_newwork;
   logic            lat_flush;
   logic [255:0]    lat_midstate;
   logic [95:0]     lat_tail;
   logic [31:0]     lat_nonce_base;

   logic            res_valid;
   logic [31:0]     res_nonce;

   logic            found_valid;
   logic            found_ready;
   logic [31:0]     found_nonce;
   logic [ID_W-1:0] found_id;

   logic            done_valid;
   logic [ID_W-1:0] done_id;
   logic            busy;
   logic [7:0]      drop_count;
   logic [1:0]      dbg_state;

   modport slave (
      input  work_valid, work_midstate, work_tail, work_id,
      input  res_valid, res_nonce, found_ready,
      output work_ready, lat_valid, lat_newwork, lat_flush, lat_midstate, lat_tail,
      output lat_nonce_base, found_valid, found_nonce, found_id,
      output done_valid, done_id, busy, drop_count, dbg_state
   );

   modport master (
      output work_valid, work_midstate, work_tail, work_id,
      output res_valid, res_nonce, found_ready,
      input  work_ready, lat_valid, lat_newwork, lat_flush, lat_midstate, lat_tail,
      input  lat_nonce_base, found_valid, found_nonce, found_id,
      input  done_valid, done_id, busy, drop_count, dbg_state
   );
endinterface

// File: rtl/lattice_scheduler.sv
// Job sequencer: broadcasts a job into the lattice, sweeps the nonce space,
// drains the pipeline and reports hits followed by a per-job done pulse.
module lattice_scheduler #(
   parameter int LOG2_NUM_CORES = 1,
   parameter int NONCE_BITS     = 32,
   parameter int PIPE_DEPTH     = 8,
   parameter int ID_W           = 8
) (
   input logic                clk,
   input logic                rst,
   lattice_scheduler_if.slave bus
);
   localparam int CW = $clog2(PIPE_DEPTH + 1);
   localparam logic [NONCE_BITS-1:0] STEP = NONCE_BITS'(1) << LOG2_NUM_CORES;
   localparam logic [NONCE_BITS-1:0] LAST = ~(STEP - NONCE_BITS'(1));

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, REPORT = 2'd3} state_t;

   state_t          state, state_nx;
   logic [NONCE_BITS-1:0] base;
   logic            first, flush_q, found_full, done_q;
   logic [CW-1:0]   drain_cnt, discard;
   logic [255:0]    midstate;
   logic [95:0]     tail;
   logic [ID_W-1:0] job_id, found_id_q, done_id_q;
   logic [31:0]     found_nonce_q;
   logic [7:0]      drops;
   logic            accept, issue, last_issue, drain_end, res_take, report_go;

   // Gated by reset so every output reads 0 while reset is held.
   assign bus.work_ready = rst && (state != REPORT);
   assign accept     = bus.work_valid && bus.work_ready;
   assign issue      = (state == RUN) && !flush_q;
   assign last_issue = issue && (base == LAST);
   assign drain_end  = (state == DRAIN) && (drain_cnt == CW'(PIPE_DEPTH - 1));
   assign res_take   = bus.res_valid && (discard == '0) && (state != IDLE);
   // Done only once the buffer is certain to be empty next cycle, so each hit precedes its done.
   assign report_go  = (state == REPORT) && (!found_full || bus.found_ready) && !res_take;

   assign bus.lat_valid      = issue;
   assign bus.lat_newwork    = issue && first;
   assign bus.lat_flush      = flush_q;
   assign bus.lat_midstate   = midstate;
   assign bus.lat_tail       = tail;
   assign bus.lat_nonce_base = 32'(base);
   assign bus.found_valid    = found_full;
   assign bus.found_nonce    = found_nonce_q;
   assign bus.found_id       = found_id_q;
   assign bus.done_valid     = done_q;
   assign bus.done_id        = done_id_q;
   assign bus.busy           = (state != IDLE);
   assign bus.drop_count     = drops;
   assign bus.dbg_state      = state;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (accept) state_nx = RUN;
                  else if (last_issue) state_nx = DRAIN;
         DRAIN:   if (accept) state_nx = RUN;
                  else if (drain_end) state_nx = REPORT;
         REPORT:  if (report_go) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base          <= '0;
         first         <= 1'b0;
         flush_q       <= 1'b0;
         drain_cnt     <= '0;
         discard       <= '0;
         midstate      <= '0;
         tail          <= '0;
         job_id        <= '0;
         found_full    <= 1'b0;
         found_nonce_q <= '0;
         found_id_q    <= '0;
         drops         <= '0;
         done_q        <= 1'b0;
         done_id_q     <= '0;
      end else begin
         done_q <= report_go;
         if (report_go) done_id_q <= job_id;

         // A preempt flushes the lattice and blanks its results for one pipeline depth.
         if (accept && (state != IDLE)) discard <= CW'(PIPE_DEPTH);
         else if (discard != '0)        discard <= discard - CW'(1);

         if (accept) begin
            midstate <= bus.work_midstate;
            tail     <= bus.work_tail;
            job_id   <= bus.work_id;
            base     <= '0;
            first    <= 1'b1;
            flush_q  <= (state != IDLE);
         end else begin
            flush_q <= 1'b0;
            if (issue) begin
               base  <= base + STEP;
               first <= 1'b0;
            end
         end

         if (state == DRAIN) drain_cnt <= drain_cnt + CW'(1);
         else                drain_cnt <= '0;

         if (res_take) begin
            if (found_full && !bus.found_ready) begin
               if (drops != 8'hff) drops <= drops + 8'd1;
            end else begin
               found_full    <= 1'b1;
               found_nonce_q <= bus.res_nonce;
               found_id_q    <= job_id;
            end
         end else if (found_full && bus.found_ready) begin
            found_full <= 1'b0;
         end
      end
   end
endmodule
